hbif_cmd_ctrl: RTL

//  Byte-protocol command controller between the UART byte stream and an internal register bus.

---
 rtl/hbif_cmd_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/hbif_cmd_ctrl.sv
// UART byte-protocol command controller: parses 'W'/'R' host frames, issues one
// register-bus access per frame and returns a single response byte.
module hbif_cmd_ctrl #(
  parameter int unsigned BYTE_TIMEOUT = 68750,
  parameter int unsigned BUS_TIMEOUT  = 255
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       rx_data_valid_i,
  input  logic [7:0] rx_data_i,
  input  logic       tx_data_ready_i,
  output logic       tx_data_valid_o,
  output logic [7:0] tx_data_o,
  output logic       bus_req_o,
  output logic       bus_we_o,
  output logic [7:0] bus_addr_o,
  output logic [7:0] bus_wdata_o,
  input  logic       bus_ack_i,
  input  logic [7:0] bus_rdata_i,
  output logic       err_o
);

  localparam int unsigned BYTE_W = $clog2(BYTE_TIMEOUT + 1);
  localparam int unsigned BUS_W  = $clog2(BUS_TIMEOUT + 1);
  // Timeouts fire in the last counted cycle so the wait spans exactly the limit.
  localparam logic [BYTE_W-1:0] BYTE_LIM = BYTE_W'(BYTE_TIMEOUT - 1);
  localparam logic [BUS_W-1:0]  BUS_LIM  = BUS_W'(BUS_TIMEOUT - 1);
  localparam logic [BYTE_W-1:0] BYTE_MAX = BYTE_W'(BYTE_TIMEOUT);
  localparam logic [BUS_W-1:0]  BUS_MAX  = BUS_W'(BUS_TIMEOUT);

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [7:0]          addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic [7:0]          tx_q, tx_d;
  logic                err_q, err_d;
  logic [BYTE_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [BUS_W-1:0]    bus_cnt_q, bus_cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      tx_q       <= '0;
      err_q      <= 1'b0;
      byte_cnt_q <= '0;
      bus_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      tx_q       <= tx_d;
      err_q      <= err_d;
      byte_cnt_q <= byte_cnt_d;
      bus_cnt_q  <= bus_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tx_d       = tx_q;
    err_d      = 1'b0;
    byte_cnt_d = byte_cnt_q;
    bus_cnt_d  = bus_cnt_q;
    if (!en_i) begin
      state_d    = IDLE;
      byte_cnt_d = '0;
      bus_cnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          byte_cnt_d = '0;
          if (rx_data_valid_i) begin
            if (rx_data_i == CMD_W || rx_data_i == CMD_R) begin
              we_d    = (rx_data_i == CMD_W);
              state_d = ADDR;
            end else begin
              tx_d    = NAK;
              err_d   = 1'b1;
              state_d = RESP;
            end
          end
        end
        ADDR, DATA: begin
          if (rx_data_valid_i) begin
            byte_cnt_d = '0;
            bus_cnt_d  = '0;
            if (state_q == ADDR) begin
              addr_d  = rx_data_i;
              state_d = we_q ? DATA : BUS;
            end else begin
              wdata_d = rx_data_i;
              state_d = BUS;
            end
          end else if (byte_cnt_q == BYTE_LIM) begin
            byte_cnt_d = '0;
            err_d      = 1'b1;
            state_d    = IDLE;
          end else if (byte_cnt_q != BYTE_MAX) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
        BUS: begin
          if (rx_data_valid_i) err_d = 1'b1;
          if (bus_ack_i) begin
            tx_d    = we_q ? ACK : bus_rdata_i;
            state_d = RESP;
          end else if (bus_cnt_q == BUS_LIM) begin
            tx_d    = NAK;
            err_d   = 1'b1;
            state_d = RESP;
          end else if (bus_cnt_q != BUS_MAX) begin
            bus_cnt_d = bus_cnt_q + 1'b1;
          end
        end
        RESP: begin
          if (rx_data_valid_i) err_d = 1'b1;
          if (tx_data_ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus_req_o       = (state_q == BUS);
  assign tx_data_valid_o = (state_q == RESP);
  assign tx_data_o       = tx_q;
  assign bus_we_o        = we_q;
  assign bus_addr_o      = addr_q;
  assign bus_wdata_o     = wdata_q;
  assign err_o           = err_q;

endmodule
